// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds requester indices, field widths and the pending-mask decode helper.
package reg_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int ENTRY_W    = REG_ADDR_W + XLEN;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // x0 is hardwired, so it never contributes a pending bit.
    function automatic logic [XLEN-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [XLEN-1:0] mask;
        mask = {XLEN{1'b0}};
        if (rd != {REG_ADDR_W{1'b0}}) begin
            mask[rd] = 1'b1;
        end else begin
            mask = {XLEN{1'b0}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_wb_fifo.sv
// Per-requester writeback queue: circular buffer with per-slot valid bits.
// Exposes each slot's rd and valid so the top can build the pending mask.
module wb_fifo
    import reg_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push,
    input  logic                                 pop,
    input  logic [WIDTH-1:0]                     din,
    output logic                                 full,
    output logic                                 empty,
    output logic [WIDTH-1:0]                     head,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_rd,
    output logic [DEPTH-1:0]                     entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             push_s;
    logic             pop_s;

    // In circular order the write slot is occupied only when every slot is.
    assign full   = valid_r[wr_ptr_r];
    assign empty  = ~valid_r[rd_ptr_r];
    assign head   = mem_r[rd_ptr_r];
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign entry_valid = valid_r;

    // Slot storage, valid bits and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r  <= {DEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r]   <= din;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Destination field of every slot, for the pending mask.
    always_comb begin
        entry_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i] = mem_r[i][WIDTH-1 -: REG_ADDR_W];
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester (ALU / load unit) register-file write arbiter.
// Round-robin between queue heads, one registered write per cycle.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]       mem_data,
    output logic                  mem_ready,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_reg,
    output logic [XLEN-1:0]       wr_data,
    output logic [XLEN-1:0]       pending_mask
);

    logic                              init_r;
    req_idx_e                          rr_ptr_r;
    req_idx_e                          rr_ptr_nxt_s;
    logic                              wr_en_r;
    logic [REG_ADDR_W-1:0]             wr_reg_r;
    logic [XLEN-1:0]                   wr_data_r;

    logic                              alu_push_s, alu_pop_s, alu_full_s, alu_empty_s;
    logic                              mem_push_s, mem_pop_s, mem_full_s, mem_empty_s;
    wb_entry_t                         alu_head_s, mem_head_s, pop_entry_s;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]  alu_ent_rd_s, mem_ent_rd_s;
    logic [DEPTH-1:0]                  alu_ent_vld_s, mem_ent_vld_s;
    logic                              pop_any_s;
    logic [XLEN-1:0]                   pend_s;

    // init_r keeps ready low until the first clock edge after reset release.
    assign alu_ready  = init_r & ~alu_full_s;
    assign mem_ready  = init_r & ~mem_full_s;
    assign alu_push_s = alu_valid & alu_ready;
    assign mem_push_s = mem_valid & mem_ready;

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (alu_push_s),
        .pop         (alu_pop_s),
        .din         ({alu_rd, alu_data}),
        .full        (alu_full_s),
        .empty       (alu_empty_s),
        .head        (alu_head_s),
        .entry_rd    (alu_ent_rd_s),
        .entry_valid (alu_ent_vld_s)
    );

    wb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_mem_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (mem_push_s),
        .pop         (mem_pop_s),
        .din         ({mem_rd, mem_data}),
        .full        (mem_full_s),
        .empty       (mem_empty_s),
        .head        (mem_head_s),
        .entry_rd    (mem_ent_rd_s),
        .entry_valid (mem_ent_vld_s)
    );

    // Round-robin grant; the pointer only advances when both heads compete.
    always_comb begin
        alu_pop_s    = 1'b0;
        mem_pop_s    = 1'b0;
        rr_ptr_nxt_s = rr_ptr_r;
        pop_entry_s  = alu_head_s;
        case ({~alu_empty_s, ~mem_empty_s})
            2'b11: begin
                if (rr_ptr_r == REQ_ALU) begin
                    alu_pop_s    = 1'b1;
                    pop_entry_s  = alu_head_s;
                    rr_ptr_nxt_s = REQ_MEM;
                end else begin
                    mem_pop_s    = 1'b1;
                    pop_entry_s  = mem_head_s;
                    rr_ptr_nxt_s = REQ_ALU;
                end
            end
            2'b10: begin
                alu_pop_s   = 1'b1;
                pop_entry_s = alu_head_s;
            end
            2'b01: begin
                mem_pop_s   = 1'b1;
                pop_entry_s = mem_head_s;
            end
            default: begin
                alu_pop_s = 1'b0;
                mem_pop_s = 1'b0;
            end
        endcase
    end

    assign pop_any_s = alu_pop_s | mem_pop_s;

    // Ready-enable flag: set on the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_r <= 1'b0;
        end else begin
            init_r <= 1'b1;
        end
    end

    // Output stage and arbitration pointer; x0 writes are popped but suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r  <= REQ_ALU;
            wr_en_r   <= 1'b0;
            wr_reg_r  <= {REG_ADDR_W{1'b0}};
            wr_data_r <= {XLEN{1'b0}};
        end else begin
            rr_ptr_r <= rr_ptr_nxt_s;
            wr_en_r  <= pop_any_s & (pop_entry_s.rd != {REG_ADDR_W{1'b0}});
            if (pop_any_s && (pop_entry_s.rd != {REG_ADDR_W{1'b0}})) begin
                wr_reg_r  <= pop_entry_s.rd;
                wr_data_r <= pop_entry_s.data;
            end
        end
    end

    // Pending mask over all queued slots plus the staged write.
    always_comb begin
        pend_s = {XLEN{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pend_s = pend_s | (alu_ent_vld_s[i] ? reg_onehot(alu_ent_rd_s[i]) : {XLEN{1'b0}});
            pend_s = pend_s | (mem_ent_vld_s[i] ? reg_onehot(mem_ent_rd_s[i]) : {XLEN{1'b0}});
        end
        pend_s = pend_s | (wr_en_r ? reg_onehot(wr_reg_r) : {XLEN{1'b0}});
    end

    assign pending_mask = pend_s;
    assign wr_en        = wr_en_r;
    assign wr_reg       = wr_reg_r;
    assign wr_data      = wr_data_r;

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, entries per requester queue (power of two, >= 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid  input  1  ALU writeback request.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 alu_ready  output  1  ALU queue can accept.
REQ-008 mem_valid  input  1  load-unit writeback request.
REQ-009 mem_rd  input  5  load destination register.
REQ-010 mem_data  input  32  load result.
REQ-011 mem_ready  output  1  load queue can accept.
REQ-012 wr_en  output  1  register file write strobe.
REQ-013 wr_reg  output  5  register file write address.
REQ-014 wr_data  output  32  register file write data.
REQ-015 pending_mask  output  32  bit i set while a write to register i is queued or staged.

Function
REQ-016 A transfer occurs on a cycle where valid and ready are both high; each requester transfers at most one entry per cycle into its own FIFO queue.
REQ-017 ready = queue not full, from registered state only; no combinational valid-to-ready path.
REQ-018 Each cycle, if at least one queue is non-empty, exactly one head is popped into the output stage.
REQ-019 Both heads present: grant the requester indicated by the round-robin pointer; the pointer then points to the other requester.
REQ-020 One head present: grant it; pointer unchanged.
REQ-021 Entries from one requester are written in acceptance order.
REQ-022 Output stage registered: a popped entry drives wr_en=1, wr_reg, wr_data for exactly one cycle, the cycle after the pop.
REQ-023 Minimum latency from transfer into an empty queue to wr_en = 2 cycles.
REQ-024 Entries with rd = 0 are accepted and popped normally but produce wr_en = 0.
REQ-025 No pop in a cycle: next cycle wr_en = 0; wr_reg and wr_data hold their last values.
REQ-026 A full queue accepts a new entry in the cycle it is popped only if ready was already high; no same-cycle pop-to-ready bypass.
REQ-027 pending_mask = OR of one-hot(rd) over all valid queue entries and the output stage while wr_en = 1; bit 0 always 0.
REQ-028 pending_mask is combinational from registered state only.
REQ-029 Same rd from both requesters: no merging or reordering; both writes issue, in grant order.

Reset
REQ-030 While rst_n = 0: both queues empty, alu_ready = mem_ready = 0, wr_en = 0, wr_reg = 0, wr_data = 0, pending_mask = 0, pointer = ALU.
REQ-031 After rst_n deasserts, alu_ready and mem_ready are 1 from the first rising edge of clk.
REQ-032 Reset mid-operation discards all queued and staged entries; no write is issued for them.

Structure
REQ-033 A shared package holds the requester index constants (ALU = 0, MEM = 1), REG_ADDR_W = 5, and XLEN = 32.
REQ-034 Sub-module wb_fifo, parameterised on DEPTH and entry width 37, is instantiated once per requester and exposes push, pop, full, empty, head, and per-entry rd/valid for the mask.

Verification
REQ-035 Reset, then ALU transfers rd=5, data=0x12345678 -> wr_en=1, wr_reg=5, wr_data=0x12345678 exactly 2 cycles later; pending_mask bit 5 set from the cycle after the transfer until wr_en drops.
REQ-036 Both queues hold 3 entries each, pointer=ALU -> writes issue alternately ALU, MEM, ALU, MEM, ALU, MEM on consecutive cycles.
REQ-037 ALU transfers rd=0, data=0xFFFFFFFF -> wr_en stays 0 for all cycles; pending_mask stays 0.
REQ-038 With DEPTH=2, MEM transfers 2 entries while blocked by continuous ALU traffic -> mem_ready=0 and a third mem_valid is not accepted; MEM entries still issue within 4 cycles (no starvation).
REQ-039 Assert rst_n=0 asynchronously, mid-cycle, with 2 entries queued -> outputs reach reset values immediately; no wr_en pulse after release.
REQ-040 Both requesters target rd=7 in the same cycle, pointer=MEM -> wr_data for MEM, then for ALU, on consecutive cycles; pending_mask bit 7 clears only after the second write.
